// File: rtl/seq_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : seq_shift_unit
//  Purpose  : Multi-cycle shift unit. Shifts a WIDTH-bit operand by a run-time
//             amount, one bit position per clock, in one of four modes:
//             SLA (arithmetic left, overflow detect), SLL (logical left),
//             SRA (arithmetic right) and ROL (rotate left).
//             A start/busy/done handshake issues one operation at a time.
//  Ports    : clk    - clock, rising edge
//             rst    - asynchronous active-high reset
//             start  - load a new operation (ignored while busy)
//             mode   - 00 SLA, 01 SLL, 10 SRA, 11 ROL (sampled with start)
//             amount - shift distance 0..WIDTH-1 (sampled with start)
//             din    - operand (sampled with start)
//             busy   - operation in progress
//             done   - one-cycle pulse, result valid on dout/ovf
//             dout   - working / result register
//             ovf    - sticky SLA overflow flag for the current operation
//  Revision : 1.0  initial release
// ============================================================================
module seq_shift_unit #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [$clog2(WIDTH)-1:0] amount,
  input  logic [WIDTH-1:0]         din,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         dout,
  output logic                     ovf
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] MODE_SLA = 2'b00;
  localparam logic [1:0] MODE_SLL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q,  mode_d;
  logic [SW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic             ovf_q,   ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_SLA;
      cnt_q   <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE lasts exactly one cycle; a start seen in it is accepted
        // directly so back-to-back operations skip the IDLE cycle.
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
        if (start) begin
          state_d = S_SHIFT;
          mode_d  = mode;
          cnt_d   = amount;
          dout_d  = din;
          ovf_d   = 1'b0;
        end
      end

      S_SHIFT: begin
        // cnt counts remaining steps; the cnt==0 cycle is the final busy
        // cycle, which gives the N+1 latency including the done transition.
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - SW'(1);
          case (mode_q)
            MODE_SLA: begin
              dout_d = {dout_q[WIDTH-2:0], 1'b0};
              // Sign would change on this step if the top two bits differ.
              ovf_d  = ovf_q | (dout_q[WIDTH-1] ^ dout_q[WIDTH-2]);
            end
            MODE_SLL: dout_d = {dout_q[WIDTH-2:0], 1'b0};
            MODE_SRA: dout_d = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
            MODE_ROL: dout_d = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
            default:  dout_d = dout_q;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign dout = dout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire
